// File: rtl/ppg_multichannel_calibrator_if.sv
// Bus between the PPG calibration controller and the ADC / AFE pins.
// The controller takes the master modport; the AFE/ADC side (or a bench)
// takes the slave modport. Parameters must match the controller instance.
interface ppg_multichannel_calibrator_if #(
  parameter int N_CH  = 2,
  parameter int ADC_W = 8,
  parameter int DC_W  = 7,
  parameter int PGA_W = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [ADC_W-1:0] ADC;
  logic             find_setting;
  logic [N_CH-1:0]  LED_EN;
  logic [DC_W-1:0]  DC_Comp;
  logic [PGA_W-1:0] PGA_Gain;
  logic             CLK_Filter;
  logic             busy;
  logic             cal_done;
  logic             cal_err;
  logic             sample_valid;
  logic [CH_W-1:0]  sample_ch;
  logic [ADC_W-1:0] sample_data;

  modport master (
    input  ADC, find_setting,
    output LED_EN, DC_Comp, PGA_Gain, CLK_Filter, busy, cal_done, cal_err,
           sample_valid, sample_ch, sample_data
  );

  modport slave (
    output ADC, find_setting,
    input  LED_EN, DC_Comp, PGA_Gain, CLK_Filter, busy, cal_done, cal_err,
           sample_valid, sample_ch, sample_data
  );
endinterface

// File: rtl/ppg_multichannel_calibrator.sv
// Multichannel LED/AFE calibration controller for the PPG front end.
// Per channel: step DC_Comp until the window average is centred, then raise
// PGA_Gain until the window clips (keeping the last clean gain). After the
// last channel it time-multiplexes the LEDs with the stored settings and
// emits one tagged ADC sample per slot.
// Optional feature macro: CALIB_TIMEOUT_EN (limits DC steps per channel and
// drives cal_err; when undefined cal_err is tied low).
module ppg_multichannel_calibrator #(
  parameter int N_CH     = 2,
  parameter int ADC_W    = 8,
  parameter int DC_W     = 7,
  parameter int PGA_W    = 4,
  parameter int WIN_LEN  = 10,
  parameter int DC_LO    = 110,
  parameter int DC_HI    = 140,
  parameter int CLIP_LO  = 5,
  parameter int CLIP_HI  = 250,
  parameter int DC_INIT  = 64,
  parameter int SLOT_LEN = 10
) (
  input  logic                           CLK,
  input  logic                           rst_n,
  ppg_multichannel_calibrator_if.master  bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WC_W = $clog2(WIN_LEN);
  localparam int SC_W = $clog2(SLOT_LEN);
  localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(WIN_LEN - 1);
  localparam logic [SC_W-1:0]  SLOT_LAST = SC_W'(SLOT_LEN - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [ADC_W:0]   AVG_LO    = (ADC_W+1)'(DC_LO);
  localparam logic [ADC_W:0]   AVG_HI    = (ADC_W+1)'(DC_HI);
  localparam logic [ADC_W-1:0] CLIP_LO_V = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0] CLIP_HI_V = ADC_W'(CLIP_HI);
  localparam logic [DC_W-1:0]  DC_START  = DC_W'(DC_INIT);
  localparam logic [N_CH-1:0]  LED0      = N_CH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_DC_WIN, S_DC_ADJ, S_PGA_WIN, S_PGA_ADJ, S_NEXT_CH, S_RUN
  } state_t;

  state_t           state_reg;
  logic [CH_W-1:0]  ch_reg, slot_reg;
  logic [WC_W-1:0]  win_cnt_reg;
  logic [SC_W-1:0]  slot_cnt_reg;
  logic [ADC_W-1:0] min_reg, max_reg;
  logic [DC_W-1:0]  dc_reg;
  logic [PGA_W-1:0] pga_reg;
  logic [N_CH-1:0]  led_reg;
  logic             busy_reg, done_reg, fs_prev_reg, clk_filter_reg;
  logic             svalid_reg;
  logic [CH_W-1:0]  sch_reg;
  logic [ADC_W-1:0] sdata_reg;
  logic [DC_W-1:0]  dc_store_reg  [N_CH];
  logic [PGA_W-1:0] pga_store_reg [N_CH];
`ifdef CALIB_TIMEOUT_EN
  localparam logic [DC_W:0] STEP_MAX = (DC_W+1)'(2**DC_W);
  logic [DC_W:0]    step_cnt_reg;
  logic             err_reg;
`endif

  logic [ADC_W:0]   sum_w, avg_w;
  logic             fs_rise, in_win, clipped, dc_step_dn, dc_step_up;
  logic [CH_W-1:0]  ch_nxt, slot_nxt;

  assign sum_w      = {1'b0, max_reg} + {1'b0, min_reg};
  assign avg_w      = sum_w >> 1;
  assign fs_rise    = bus.find_setting & ~fs_prev_reg;
  assign in_win     = (state_reg == S_DC_WIN) || (state_reg == S_PGA_WIN);
  assign clipped    = (min_reg <= CLIP_LO_V) || (max_reg >= CLIP_HI_V);
  // A step that would wrap the DC code is refused; the code is kept instead.
  assign dc_step_dn = (avg_w < AVG_LO) && (dc_reg != '0);
  assign dc_step_up = (avg_w > AVG_HI) && (dc_reg != '1);
  assign ch_nxt     = ch_reg + 1'b1;
  assign slot_nxt   = (slot_reg == CH_LAST) ? '0 : slot_reg + 1'b1;

  // Free-running CLK/2 for the switched-cap filter.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) clk_filter_reg <= 1'b0;
    else        clk_filter_reg <= ~clk_filter_reg;
  end

  // Calibration / run sequencer with window min/max tracking and settings store.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      ch_reg       <= '0;
      slot_reg     <= '0;
      win_cnt_reg  <= '0;
      slot_cnt_reg <= '0;
      min_reg      <= '0;
      max_reg      <= '0;
      dc_reg       <= DC_START;
      pga_reg      <= '0;
      led_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fs_prev_reg  <= 1'b0;
      svalid_reg   <= 1'b0;
      sch_reg      <= '0;
      sdata_reg    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        dc_store_reg[i]  <= '0;
        pga_store_reg[i] <= '0;
      end
`ifdef CALIB_TIMEOUT_EN
      step_cnt_reg <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      fs_prev_reg <= bus.find_setting;
      svalid_reg  <= 1'b0;

      // Window counter only runs inside a window, so every entry starts at 0
      // and the first sample reloads min/max.
      if (in_win) begin
        win_cnt_reg <= win_cnt_reg + 1'b1;
        if (win_cnt_reg == '0) begin
          min_reg <= bus.ADC;
          max_reg <= bus.ADC;
        end else begin
          if (bus.ADC < min_reg) min_reg <= bus.ADC;
          if (bus.ADC > max_reg) max_reg <= bus.ADC;
        end
      end else begin
        win_cnt_reg <= '0;
      end

      if (state_reg != S_IDLE && !bus.find_setting) begin
        state_reg <= S_IDLE;
        led_reg   <= '0;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b0;
      end else if (fs_rise && (state_reg == S_IDLE || state_reg == S_RUN)) begin
        state_reg <= S_DC_WIN;
        ch_reg    <= '0;
        busy_reg  <= 1'b1;
        done_reg  <= 1'b0;
        dc_reg    <= DC_START;
        pga_reg   <= '0;
        led_reg   <= LED0;
`ifdef CALIB_TIMEOUT_EN
        err_reg      <= 1'b0;
        step_cnt_reg <= '0;
`endif
      end else begin
        case (state_reg)
          S_DC_WIN:  if (win_cnt_reg == WIN_LAST) state_reg <= S_DC_ADJ;
          S_PGA_WIN: if (win_cnt_reg == WIN_LAST) state_reg <= S_PGA_ADJ;
          S_DC_ADJ: begin
            if (dc_step_dn || dc_step_up) begin
`ifdef CALIB_TIMEOUT_EN
              if (step_cnt_reg == STEP_MAX) begin
                err_reg   <= 1'b1;
                busy_reg  <= 1'b0;
                led_reg   <= '0;
                state_reg <= S_IDLE;
              end else begin
                step_cnt_reg <= step_cnt_reg + 1'b1;
`endif
                dc_reg    <= dc_step_up ? dc_reg + 1'b1 : dc_reg - 1'b1;
                state_reg <= S_DC_WIN;
`ifdef CALIB_TIMEOUT_EN
              end
`endif
            end else begin
              dc_store_reg[ch_reg] <= dc_reg;
              state_reg            <= S_PGA_WIN;
            end
          end
          S_PGA_ADJ: begin
            if (clipped) begin
              pga_store_reg[ch_reg] <= (pga_reg == '0) ? '0 : pga_reg - 1'b1;
              state_reg             <= S_NEXT_CH;
            end else if (pga_reg == '1) begin
              pga_store_reg[ch_reg] <= pga_reg;
              state_reg             <= S_NEXT_CH;
            end else begin
              pga_reg   <= pga_reg + 1'b1;
              state_reg <= S_PGA_WIN;
            end
          end
          S_NEXT_CH: begin
            if (ch_reg == CH_LAST) begin
              state_reg    <= S_RUN;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
              slot_reg     <= '0;
              slot_cnt_reg <= '0;
              led_reg      <= LED0;
              dc_reg       <= dc_store_reg[0];
              pga_reg      <= pga_store_reg[0];
            end else begin
              ch_reg    <= ch_nxt;
              state_reg <= S_DC_WIN;
              dc_reg    <= DC_START;
              pga_reg   <= '0;
              led_reg   <= LED0 << ch_nxt;
`ifdef CALIB_TIMEOUT_EN
              step_cnt_reg <= '0;
`endif
            end
          end
          S_RUN: begin
            if (slot_cnt_reg == SLOT_LAST) begin
              svalid_reg   <= 1'b1;
              sch_reg      <= slot_reg;
              sdata_reg    <= bus.ADC;
              slot_cnt_reg <= '0;
              slot_reg     <= slot_nxt;
              led_reg      <= LED0 << slot_nxt;
              dc_reg       <= dc_store_reg[slot_nxt];
              pga_reg      <= pga_store_reg[slot_nxt];
            end else begin
              slot_cnt_reg <= slot_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.LED_EN       = led_reg;
  assign bus.DC_Comp      = dc_reg;
  assign bus.PGA_Gain     = pga_reg;
  assign bus.CLK_Filter   = clk_filter_reg;
  assign bus.busy         = busy_reg;
  assign bus.cal_done     = done_reg;
  assign bus.sample_valid = svalid_reg;
  assign bus.sample_ch    = sch_reg;
  assign bus.sample_data  = sdata_reg;
`ifdef CALIB_TIMEOUT_EN
  assign bus.cal_err      = err_reg;
`else
  assign bus.cal_err      = 1'b0;
`endif
endmodule

// File: tb/tb_ppg_multichannel_calibrator.sv
// Directed bench for ppg_multichannel_calibrator (default build, 2 channels).
// A small plant model turns LED/DC/PGA outputs into ADC codes; expected
// settings and timings are worked out by hand from the parameters.
module tb_ppg_multichannel_calibrator;
  localparam int N_CH = 2, ADC_W = 8, DC_W = 7, PGA_W = 4;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_bad = 0;
  int   mode = 1;
  logic tgl = 1'b0;

  always #5 CLK = ~CLK;

  ppg_multichannel_calibrator_if #(.N_CH(N_CH), .ADC_W(ADC_W), .DC_W(DC_W), .PGA_W(PGA_W)) bus ();

  ppg_multichannel_calibrator #(.N_CH(N_CH), .ADC_W(ADC_W), .DC_W(DC_W), .PGA_W(PGA_W)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Plant: mode 1 flat 125; mode 2 ch0 avg 100+5*(64-DC) and 252 once gain>=6,
  // ch1 alternates 3/247; mode 3 ch0 flat 200, ch1 flat 50.
  always @(negedge CLK) begin
    int v;
    tgl = ~tgl;
    case (mode)
      2: begin
        if (bus.LED_EN == 2'b01) begin
          v = 100 + 5 * (64 - int'(bus.DC_Comp));
          if (v < 0) v = 0;
          if (v > 255) v = 255;
          bus.ADC = (bus.PGA_Gain >= 4'd6) ? 8'd252 : 8'(v);
        end else begin
          bus.ADC = tgl ? 8'd3 : 8'd247;
        end
      end
      3:       bus.ADC = (bus.LED_EN == 2'b01) ? 8'd200 : 8'd50;
      default: bus.ADC = 8'd125;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic wait_done(input int bound);
    int cyc;
    cyc = 0;
    while (bus.cal_done !== 1'b1 && cyc < bound) begin
      @(negedge CLK);
      cyc++;
    end
    check("done_in_time", 32'(bus.cal_done), 1);
  endtask

  // Called on the first RUN cycle: slot0, then slot1 after 10, slot0 after 20.
  task automatic check_run(input string t, input int dc0, input int pga0,
                           input int dc1, input int pga1, input int data0);
    check({t, "_led0"}, 32'(bus.LED_EN), 1);
    check({t, "_dc0"},  32'(bus.DC_Comp), dc0);
    check({t, "_pga0"}, 32'(bus.PGA_Gain), pga0);
    repeat (9) @(negedge CLK);
    check({t, "_sv_early"}, 32'(bus.sample_valid), 0);
    @(negedge CLK);
    check({t, "_sv0"},  32'(bus.sample_valid), 1);
    check({t, "_sch0"}, 32'(bus.sample_ch), 0);
    if (data0 >= 0) check({t, "_sdata0"}, 32'(bus.sample_data), data0);
    check({t, "_led1"}, 32'(bus.LED_EN), 2);
    check({t, "_dc1"},  32'(bus.DC_Comp), dc1);
    check({t, "_pga1"}, 32'(bus.PGA_Gain), pga1);
    repeat (10) @(negedge CLK);
    check({t, "_sv1"},  32'(bus.sample_valid), 1);
    check({t, "_sch1"}, 32'(bus.sample_ch), 1);
    check({t, "_led2"}, 32'(bus.LED_EN), 1);
  endtask

  initial begin
    int cyc, led1_at, nsv;
    bus.ADC = 8'd125;
    bus.find_setting = 1'b0;
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;

    // Reset state
    check("rst_led", 32'(bus.LED_EN), 0);
    check("rst_dc", 32'(bus.DC_Comp), 64);
    check("rst_pga", 32'(bus.PGA_Gain), 0);
    check("rst_clkf", 32'(bus.CLK_Filter), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.cal_done), 0);
    check("rst_err", 32'(bus.cal_err), 0);
    check("rst_sv", 32'(bus.sample_valid), 0);
    check("rst_sdata", 32'(bus.sample_data), 0);
    @(negedge CLK);
    check("clkf_1", 32'(bus.CLK_Filter), 1);
    @(negedge CLK);
    check("clkf_2", 32'(bus.CLK_Filter), 0);

    // Flat 125: DC stays 64, gain climbs to 15; done 2*187+3 cycles after start
    mode = 1;
    bus.find_setting = 1'b1;
    @(negedge CLK);
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_led", 32'(bus.LED_EN), 1);
    cyc = 1;
    led1_at = 0;
    while (bus.cal_done !== 1'b1 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      if (bus.LED_EN == 2'b10 && led1_at == 0) led1_at = cyc;
    end
    check("t1_done_cycle", cyc, 377);
    check("t1_ch1_start", led1_at, 189);
    check("t1_busy_end", 32'(bus.busy), 0);
    check_run("t1", 64, 15, 64, 15, 125);

    // Slot rotation: strobes 10 cycles apart, channels 0,1,0,1
    nsv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (bus.sample_valid === 1'b1) begin
        check("t4_sv_cycle", k, 10 * (nsv + 1));
        check("t4_sv_ch", 32'(bus.sample_ch), nsv % 2);
        nsv++;
      end
    end
    check("t4_sv_count", nsv, 4);

    // Drop from RUN, then DC stepping 64->63->62 and abort in PGA_WIN
    bus.find_setting = 1'b0;
    @(negedge CLK);
    check("t5_run_abort_led", 32'(bus.LED_EN), 0);
    check("t5_run_abort_done", 32'(bus.cal_done), 0);
    mode = 2;
    bus.find_setting = 1'b1;
    @(negedge CLK);
    check("t2_dc_first", 32'(bus.DC_Comp), 64);
    repeat (19) @(negedge CLK);
    check("t2_dc_step1", 32'(bus.DC_Comp), 63);
    repeat (20) @(negedge CLK);
    check("t2_dc_step2", 32'(bus.DC_Comp), 62);
    check("t5_busy_pga", 32'(bus.busy), 1);
    bus.find_setting = 1'b0;
    @(negedge CLK);
    check("t5_abort_led", 32'(bus.LED_EN), 0);
    check("t5_abort_busy", 32'(bus.busy), 0);
    bus.find_setting = 1'b1;
    @(negedge CLK);
    check("t5_restart_led", 32'(bus.LED_EN), 1);
    check("t5_restart_dc", 32'(bus.DC_Comp), 64);
    check("t5_restart_busy", 32'(bus.busy), 1);
    wait_done(3000);
    check_run("t3", 62, 5, 64, 0, 110);

    // Clamp: ch0 saturates high at 127, ch1 bottoms out at 0
    bus.find_setting = 1'b0;
    @(negedge CLK);
    mode = 3;
    bus.find_setting = 1'b1;
    @(negedge CLK);
    wait_done(6000);
    check_run("t6", 127, 15, 0, 15, 200);

    // Asynchronous reset in the middle of calibration
    bus.find_setting = 1'b0;
    @(negedge CLK);
    mode = 1;
    bus.find_setting = 1'b1;
    repeat (30) @(negedge CLK);
    check("t7_pga_before", 32'(bus.PGA_Gain), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_led", 32'(bus.LED_EN), 0);
    check("t7_rst_busy", 32'(bus.busy), 0);
    check("t7_rst_dc", 32'(bus.DC_Comp), 64);
    check("t7_rst_pga", 32'(bus.PGA_Gain), 0);
    bus.find_setting = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
